// File: rtl/upc_scan_session.sv
// Scan session classifier: programmable UPC table, per-session counts
// and a latched theft alarm with one-cycle classification latency.
module upc_scan_session #(
    parameter int UPC_W        = 3,
    parameter int CNT_W        = 8,
    parameter int ALARM_THRESH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [UPC_W-1:0] cfg_addr,
    input  logic             cfg_disc,
    input  logic             cfg_exp,
    input  logic             scan_valid,
    input  logic [UPC_W-1:0] scan_upc,
    input  logic             scan_mark,
    input  logic             session_end,
    input  logic             alarm_clr,
    output logic             out_valid,
    output logic             discounted,
    output logic             stolen,
    output logic [CNT_W-1:0] item_count,
    output logic [CNT_W-1:0] stolen_count,
    output logic [CNT_W-1:0] disc_count,
    output logic             alarm
);

    localparam int               DEPTH = 2 ** UPC_W;
    localparam logic [CNT_W-1:0] CMAX  = '1;
    localparam logic [CNT_W-1:0] THR   = CNT_W'(ALARM_THRESH);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        ALARM
    } state_t;

    state_t state;
    state_t state_nx;

    // bit 1 = discounted, bit 0 = expensive
    logic [1:0] tbl [DEPTH];

    logic             cls_disc;
    logic             cls_stl;
    logic             take;
    logic             count;
    logic             wipe;
    logic [CNT_W-1:0] item_nx;
    logic [CNT_W-1:0] stl_nx;
    logic [CNT_W-1:0] disc_nx;

    function automatic logic [CNT_W-1:0] bump(
        input logic [CNT_W-1:0] v,
        input logic             en
    );
        return (en && v != CMAX) ? v + CNT_W'(1) : v;
    endfunction

    // Read happens before the same-edge write, so a colliding scan sees the old entry
    assign cls_disc = tbl[scan_upc][1];
    assign cls_stl  = tbl[scan_upc][0] & ~scan_mark;
    assign alarm    = (state == ALARM);

    // Table write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= '0;
            end
        end else if (cfg_we) begin
            tbl[cfg_addr] <= {cfg_disc, cfg_exp};
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, accept/count decisions and counter next values
    always_comb begin
        state_nx = state;
        take     = 1'b0;
        count    = 1'b0;
        wipe     = 1'b0;
        unique case (state)
            IDLE: begin
                if (scan_valid) begin
                    take     = 1'b1;
                    count    = 1'b1;
                    state_nx = SCAN;
                end
            end
            SCAN: begin
                take = scan_valid;
                if (session_end) begin
                    wipe     = 1'b1;
                    state_nx = IDLE;
                end else begin
                    count = scan_valid;
                end
            end
            ALARM: begin
                if (alarm_clr) begin
                    wipe     = 1'b1;
                    state_nx = IDLE;
                end else begin
                    take  = scan_valid;
                    count = scan_valid;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        item_nx = bump(item_count, count);
        stl_nx  = bump(stolen_count, count & cls_stl);
        disc_nx = bump(disc_count, count & cls_disc);

        if (state != ALARM && count && cls_stl && stl_nx == THR) begin
            state_nx = ALARM;
        end

        if (wipe) begin
            item_nx = '0;
            stl_nx  = '0;
            disc_nx = '0;
        end
    end

    // Classification outputs and session counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            discounted   <= 1'b0;
            stolen       <= 1'b0;
            item_count   <= '0;
            stolen_count <= '0;
            disc_count   <= '0;
        end else begin
            out_valid <= take;
            if (take) begin
                discounted <= cls_disc;
                stolen     <= cls_stl;
            end
            item_count   <= item_nx;
            stolen_count <= stl_nx;
            disc_count   <= disc_nx;
        end
    end

endmodule

// File: tb/tb_upc_scan_session.sv
// Randomised and directed bench for upc_scan_session against a
// behavioural session model.
module tb_upc_scan_session;

    localparam int UPC_W  = 3;
    localparam int CNT_W  = 8;
    localparam int THRESH = 2;
    localparam int CMAX   = 255;

    logic             clk;
    logic             reset;
    logic             cfg_we;
    logic [UPC_W-1:0] cfg_addr;
    logic             cfg_disc;
    logic             cfg_exp;
    logic             scan_valid;
    logic [UPC_W-1:0] scan_upc;
    logic             scan_mark;
    logic             session_end;
    logic             alarm_clr;
    logic             out_valid;
    logic             discounted;
    logic             stolen;
    logic [CNT_W-1:0] item_count;
    logic [CNT_W-1:0] stolen_count;
    logic [CNT_W-1:0] disc_count;
    logic             alarm;

    upc_scan_session #(
        .UPC_W       (UPC_W),
        .CNT_W       (CNT_W),
        .ALARM_THRESH(THRESH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_disc    (cfg_disc),
        .cfg_exp     (cfg_exp),
        .scan_valid  (scan_valid),
        .scan_upc    (scan_upc),
        .scan_mark   (scan_mark),
        .session_end (session_end),
        .alarm_clr   (alarm_clr),
        .out_valid   (out_valid),
        .discounted  (discounted),
        .stolen      (stolen),
        .item_count  (item_count),
        .stolen_count(stolen_count),
        .disc_count  (disc_count),
        .alarm       (alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    // model: table, session flags and plain integer counts
    bit [1:0] m_tbl [8];
    bit       m_act;
    bit       m_alm;
    int       m_item;
    int       m_stl;
    int       m_disc;
    bit       e_ov;
    bit       e_disc;
    bit       e_stl;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_tbl[i] = 2'b00;
        m_act  = 0;
        m_alm  = 0;
        m_item = 0;
        m_stl  = 0;
        m_disc = 0;
        e_ov   = 0;
        e_disc = 0;
        e_stl  = 0;
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic model_step();
        bit d;
        bit s;
        bit closing;
        e_ov    = 0;
        closing = m_act && !m_alm && session_end;
        if (m_alm && alarm_clr) begin
            m_alm  = 0;
            m_act  = 0;
            m_item = 0;
            m_stl  = 0;
            m_disc = 0;
        end else begin
            if (scan_valid) begin
                d      = m_tbl[scan_upc][1];
                s      = m_tbl[scan_upc][0] && !scan_mark;
                e_ov   = 1;
                e_disc = d;
                e_stl  = s;
                if (!closing) begin
                    m_act  = 1;
                    m_item = sat(m_item);
                    if (d) m_disc = sat(m_disc);
                    if (s) begin
                        m_stl = sat(m_stl);
                        if (!m_alm && m_stl == THRESH) m_alm = 1;
                    end
                end
            end
            if (closing) begin
                m_act  = 0;
                m_item = 0;
                m_stl  = 0;
                m_disc = 0;
            end
        end
        if (cfg_we) m_tbl[cfg_addr] = {cfg_disc, cfg_exp};
    endtask

    task automatic check_all();
        chk("out_valid", 32'(out_valid), 32'(e_ov));
        chk("discounted", 32'(discounted), 32'(e_disc));
        chk("stolen", 32'(stolen), 32'(e_stl));
        chk("item_count", 32'(item_count), 32'(m_item));
        chk("stolen_count", 32'(stolen_count), 32'(m_stl));
        chk("disc_count", 32'(disc_count), 32'(m_disc));
        chk("alarm", 32'(alarm), 32'(m_alm));
    endtask

    task automatic quiet();
        cfg_we      = 0;
        cfg_addr    = '0;
        cfg_disc    = 0;
        cfg_exp     = 0;
        scan_valid  = 0;
        scan_upc    = '0;
        scan_mark   = 0;
        session_end = 0;
        alarm_clr   = 0;
    endtask

    // one clock: model sees pre-edge inputs, DUT sampled 1 unit after edge
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
        quiet();
    endtask

    task automatic scan(input int upc, input bit mark);
        scan_valid = 1;
        scan_upc   = UPC_W'(upc);
        scan_mark  = mark;
        cycle();
    endtask

    task automatic write(input int a, input bit d, input bit e);
        cfg_we   = 1;
        cfg_addr = UPC_W'(a);
        cfg_disc = d;
        cfg_exp  = e;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        quiet();
        model_reset();
        reset = 1;
        #2;
        check_all();
        @(negedge clk);
        reset = 0;

        // plain item on empty table
        scan(5, 0);
        chk("t1_ov", 32'(out_valid), 1);
        chk("t1_item", 32'(item_count), 1);
        cycle();
        chk("t1_ov_drop", 32'(out_valid), 0);

        // discounted + expensive entry
        write(3, 1, 1);
        cycle();
        scan(3, 0);
        chk("t2_stolen", 32'(stolen), 1);
        chk("t2_disc", 32'(discounted), 1);
        chk("t2_stlcnt", 32'(stolen_count), 1);
        scan(3, 1);
        chk("t2_mark", 32'(stolen), 0);
        chk("t2_disccnt", 32'(disc_count), 2);
        session_end = 1;
        cycle();
        chk("t2_end", 32'(item_count), 0);

        // alarm at threshold, session_end ignored, alarm_clr wins
        scan(3, 0);
        chk("t3_no_alarm", 32'(alarm), 0);
        scan(3, 0);
        chk("t3_alarm", 32'(alarm), 1);
        session_end = 1;
        cycle();
        chk("t3_end_ign", 32'(alarm), 1);
        chk("t3_end_cnt", 32'(item_count), 2);
        alarm_clr  = 1;
        scan_valid = 1;
        scan_upc   = 3'd1;
        cycle();
        chk("t3_clr", 32'(alarm), 0);
        chk("t3_clr_drop", 32'(out_valid), 0);
        chk("t3_clr_stl", 32'(stolen_count), 0);
        scan(1, 0);
        chk("t3_idle_item", 32'(item_count), 1);

        // write and scan same address same cycle
        write(6, 0, 1);
        scan(6, 0);
        chk("t4_old", 32'(stolen), 0);
        scan(6, 0);
        chk("t4_new", 32'(stolen), 1);
        alarm_clr = 1;
        cycle();
        session_end = 1;
        cycle();

        // saturation
        for (int i = 0; i < CMAX + 5; i++) scan(5, 0);
        chk("t5_sat", 32'(item_count), CMAX);
        session_end = 1;
        cycle();
        chk("t5_end", 32'(item_count), 0);

        // asynchronous reset between edges
        write(2, 1, 0);
        cycle();
        scan(2, 0);
        scan(2, 0);
        #2;
        reset = 1;
        #1;
        model_reset();
        chk("t6_ov", 32'(out_valid), 0);
        chk("t6_disc", 32'(discounted), 0);
        chk("t6_item", 32'(item_count), 0);
        chk("t6_dcnt", 32'(disc_count), 0);
        @(negedge clk);
        reset = 0;
        scan(2, 0);
        chk("t6_tbl_clr", 32'(discounted), 0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            cfg_we      = ($urandom % 4) == 0;
            cfg_addr    = UPC_W'($urandom);
            cfg_disc    = 1'($urandom);
            cfg_exp     = 1'($urandom);
            scan_valid  = ($urandom % 3) != 0;
            scan_upc    = UPC_W'($urandom);
            scan_mark   = 1'($urandom);
            session_end = ($urandom % 12) == 0;
            alarm_clr   = ($urandom % 6) == 0;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
